// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: write/read address sequencing for a two-bank ping-pong buffer.
// Define PINGPONG_CTRL_OVF_DET_EN to build the sticky write-overflow flag o_ovf.
module pingpong_ctrl #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_data_din_vld,
    output logic              o_din_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_switch_pingpong,
    output logic              o_bank_ready,
    input  logic              i_conv_start,
    output logic [ADDR_W-1:0] o_conv_addr,
    output logic              o_conv_addr_vld,
    output logic              o_conv_dout_vld,
    output logic              o_conv_done,
    output logic              o_ovf
);

    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] conv_addr_q, conv_addr_d;
    logic              wfull_q, wfull_d;
    logic              switch_q, switch_d;
    logic              bank_ready_q, bank_ready_d;
    logic              dout_vld_q, dout_vld_d;
    logic              done_q, done_d;

    logic din_ready;
    logic wr_en;
    logic addr_vld;
    logic swap;
    logic start;

    // Swap needs a full write bank and an empty read side; start needs a ready
    // bank, so the two can never fire on the same edge.
    always_comb begin
        din_ready = i_en & ~wfull_q;
        wr_en     = i_data_din_vld & din_ready;
        addr_vld  = i_en & (rd_state_q == R_READ);
        swap      = i_en & wfull_q & (rd_state_q == R_IDLE) & ~bank_ready_q;
        start     = i_en & i_conv_start & bank_ready_q & (rd_state_q == R_IDLE);

        wr_addr_d    = wr_addr_q;
        wfull_d      = wfull_q;
        switch_d     = switch_q;
        bank_ready_d = bank_ready_q;
        rd_state_d   = rd_state_q;
        conv_addr_d  = conv_addr_q;

        if (wr_en) begin
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d = '0;
                wfull_d   = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_ONE;
            end
        end

        if (swap) begin
            switch_d     = ~switch_q;
            wfull_d      = 1'b0;
            bank_ready_d = 1'b1;
        end

        if (start) begin
            rd_state_d   = R_READ;
            bank_ready_d = 1'b0;
            conv_addr_d  = '0;
        end

        if (addr_vld) begin
            if (conv_addr_q == LAST_ADDR) begin
                rd_state_d  = R_IDLE;
                conv_addr_d = '0;
            end else begin
                conv_addr_d = conv_addr_q + ADDR_ONE;
            end
        end

        // Read data trails the issued address by the buffer's one-cycle latency.
        dout_vld_d = addr_vld;
        done_d     = addr_vld & (conv_addr_q == LAST_ADDR);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_state_q   <= R_IDLE;
            wr_addr_q    <= '0;
            conv_addr_q  <= '0;
            wfull_q      <= 1'b0;
            switch_q     <= 1'b0;
            bank_ready_q <= 1'b0;
            dout_vld_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            wr_addr_q    <= wr_addr_d;
            conv_addr_q  <= conv_addr_d;
            wfull_q      <= wfull_d;
            switch_q     <= switch_d;
            bank_ready_q <= bank_ready_d;
            dout_vld_q   <= dout_vld_d;
            done_q       <= done_d;
        end
    end

`ifdef PINGPONG_CTRL_OVF_DET_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (i_data_din_vld & ~din_ready);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_din_ready       = din_ready;
    assign o_wr_en           = wr_en;
    assign o_wr_addr         = wr_addr_q;
    assign o_switch_pingpong = switch_q;
    assign o_bank_ready      = bank_ready_q;
    assign o_conv_addr       = conv_addr_q;
    assign o_conv_addr_vld   = addr_vld;
    assign o_conv_dout_vld   = dout_vld_q;
    assign o_conv_done       = done_q;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl: directed scenarios plus a randomized run against a
// word-counting reference model of the ping-pong controller.
module tb_pingpong_ctrl;

    localparam int DEPTH  = 768;
    localparam int ADDR_W = 10;
    localparam int VEC_W  = 2 * ADDR_W + 8;

`ifdef PINGPONG_CTRL_OVF_DET_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic              i_data_din_vld;
    logic              i_conv_start;
    logic              o_din_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_switch_pingpong;
    logic              o_bank_ready;
    logic [ADDR_W-1:0] o_conv_addr;
    logic              o_conv_addr_vld;
    logic              o_conv_dout_vld;
    logic              o_conv_done;
    logic              o_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int addr_vld_cnt = 0;
    int done_cnt     = 0;

    pingpong_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_en             (i_en),
        .i_data_din_vld   (i_data_din_vld),
        .o_din_ready      (o_din_ready),
        .o_wr_en          (o_wr_en),
        .o_wr_addr        (o_wr_addr),
        .o_switch_pingpong(o_switch_pingpong),
        .o_bank_ready     (o_bank_ready),
        .i_conv_start     (i_conv_start),
        .o_conv_addr      (o_conv_addr),
        .o_conv_addr_vld  (o_conv_addr_vld),
        .o_conv_dout_vld  (o_conv_dout_vld),
        .o_conv_done      (o_conv_done),
        .o_ovf            (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_conv_addr_vld === 1'b1) addr_vld_cnt++;
        if (o_conv_done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        i_rst = 1'b1; i_en = 1'b1; i_data_din_vld = 1'b0; i_conv_start = 1'b0;
        cyc(); cyc();
        flags = {o_switch_pingpong, o_bank_ready, o_conv_addr_vld, o_conv_dout_vld,
                 o_conv_done, o_ovf, o_din_ready, o_wr_en};
        n_checks++;
        if (flags !== 8'b0000_0010) $display("[TB] FAIL reset_flags: got %b expected %b", flags, 8'b0000_0010);
        else n_pass++;
        n_checks++;
        if ({o_wr_addr, o_conv_addr} !== '0) $display("[TB] FAIL reset_addrs: got %h/%h expected 0/0", o_wr_addr, o_conv_addr);
        else n_pass++;
        // Writes requested while reset is held must not advance the counter.
        i_data_din_vld = 1'b1;
        cyc(); cyc();
        n_checks++;
        if (o_wr_addr !== '0) $display("[TB] FAIL reset_priority: got wr_addr %0d expected 0", o_wr_addr);
        else n_pass++;
        i_data_din_vld = 1'b0;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_fill();
        logic [ADDR_W+1:0] act, exp;
        logic [ADDR_W+3:0] act2, exp2;
        i_data_din_vld = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            act = {o_din_ready, o_wr_en, o_wr_addr};
            exp = {1'b1, 1'b1, ADDR_W'(i)};
            n_checks++;
            if (act !== exp) $display("[TB] FAIL fill_word%0d: got %h expected %h", i, act, exp);
            else n_pass++;
            cyc();
        end
        act2 = {o_din_ready, o_wr_en, o_wr_addr, o_switch_pingpong, o_bank_ready};
        exp2 = '0;
        n_checks++;
        if (act2 !== exp2) $display("[TB] FAIL fill_full_cycle: got %h expected %h", act2, exp2);
        else n_pass++;
        cyc();
        exp2 = {1'b1, 1'b1, ADDR_W'(0), 1'b1, 1'b1};
        act2 = {o_din_ready, o_wr_en, o_wr_addr, o_switch_pingpong, o_bank_ready};
        n_checks++;
        if (act2 !== exp2) $display("[TB] FAIL fill_swap: got %h expected %h", act2, exp2);
        else n_pass++;
    endtask

    // Producer keeps writing, so the second bank fills while the first is read.
    task automatic test_read_back_to_back();
        logic [ADDR_W+15:0] act, exp;
        logic [6:0] f_act, f_exp;
        i_conv_start = 1'b1;
        #1;
        cyc();
        for (int k = 0; k < DEPTH; k++) begin
            i_conv_start = 1'($urandom_range(0, 1));
            #1;
            act = {o_conv_addr_vld, o_conv_addr, o_conv_dout_vld, o_conv_done, o_bank_ready,
                   o_din_ready, o_wr_addr};
            exp = {1'b1, ADDR_W'(k), (k > 0) ? 1'b1 : 1'b0, 1'b0, 1'b0,
                   (k < DEPTH - 1) ? 1'b1 : 1'b0, (k < DEPTH - 1) ? ADDR_W'(k + 1) : ADDR_W'(0)};
            n_checks++;
            if (act !== exp) $display("[TB] FAIL read_addr%0d: got %h expected %h", k, act, exp);
            else n_pass++;
            cyc();
        end
        i_conv_start = 1'b1;
        #1;
        f_act = {o_conv_addr_vld, o_conv_dout_vld, o_conv_done, o_din_ready,
                 o_switch_pingpong, o_bank_ready, (o_conv_addr == '0)};
        f_exp = 7'b0110_101;
        n_checks++;
        if (f_act !== f_exp) $display("[TB] FAIL read_done_cycle: got %b expected %b", f_act, f_exp);
        else n_pass++;
        cyc();
        i_conv_start = 1'b0;
        #1;
        f_act = {o_conv_addr_vld, o_conv_dout_vld, o_conv_done, o_din_ready,
                 o_switch_pingpong, o_bank_ready, (o_conv_addr == '0)};
        f_exp = 7'b0001_011;
        n_checks++;
        if (f_act !== f_exp) $display("[TB] FAIL second_swap: got %b expected %b", f_act, f_exp);
        else n_pass++;
    endtask

    task automatic test_enable_pause();
        logic [ADDR_W:0]        a_act, a_exp;
        logic [2*ADDR_W+3:0]    p_act, p_exp;
        logic [2:0]             d_act;
        int                     base;
        i_data_din_vld = 1'b0;
        i_conv_start   = 1'b1;
        #1;
        cyc();
        i_conv_start = 1'b0;
        #1;
        base = addr_vld_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            a_act = {o_conv_addr_vld, o_conv_addr};
            a_exp = {1'b1, ADDR_W'(k)};
            n_checks++;
            if (a_act !== a_exp) $display("[TB] FAIL pause_addr%0d: got %h expected %h", k, a_act, a_exp);
            else n_pass++;
            cyc();
            if (k == 100) begin
                i_en = 1'b0;
                i_data_din_vld = 1'b1;
                #1;
                for (int p = 0; p < 5; p++) begin
                    p_act = {o_conv_addr_vld, o_conv_addr, o_wr_en, o_din_ready, o_wr_addr, o_conv_dout_vld};
                    p_exp = {1'b0, ADDR_W'(101), 1'b0, 1'b0, ADDR_W'(0), (p == 0) ? 1'b1 : 1'b0};
                    n_checks++;
                    if (p_act !== p_exp) $display("[TB] FAIL pause_hold%0d: got %h expected %h", p, p_act, p_exp);
                    else n_pass++;
                    cyc();
                end
                i_en = 1'b1;
                i_data_din_vld = 1'b0;
                #1;
            end
        end
        d_act = {o_conv_addr_vld, o_conv_dout_vld, o_conv_done};
        n_checks++;
        if (d_act !== 3'b011) $display("[TB] FAIL pause_done: got %b expected 011", d_act);
        else n_pass++;
        cyc();
        n_checks++;
        if (addr_vld_cnt - base !== DEPTH) $display("[TB] FAIL pause_total: got %0d expected %0d", addr_vld_cnt - base, DEPTH);
        else n_pass++;
    endtask

    task automatic test_reset_midread();
        logic [ADDR_W:0]     a_act;
        logic [2*ADDR_W+5:0] z_act;
        logic [1:0]          s_act;
        int                  d0;
        i_data_din_vld = 1'b1;
        #1;
        repeat (DEPTH) cyc();
        i_data_din_vld = 1'b0;
        #1;
        cyc();
        s_act = {o_switch_pingpong, o_bank_ready};
        n_checks++;
        if (s_act !== 2'b11) $display("[TB] FAIL midread_swap: got %b expected 11", s_act);
        else n_pass++;
        i_conv_start = 1'b1;
        #1;
        cyc();
        i_conv_start = 1'b0;
        #1;
        repeat (300) cyc();
        a_act = {o_conv_addr_vld, o_conv_addr};
        n_checks++;
        if (a_act !== {1'b1, ADDR_W'(300)}) $display("[TB] FAIL midread_at300: got %h expected %h", a_act, {1'b1, ADDR_W'(300)});
        else n_pass++;
        d0 = done_cnt;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        #1;
        z_act = {o_wr_addr, o_conv_addr, o_switch_pingpong, o_bank_ready, o_conv_addr_vld,
                 o_conv_dout_vld, o_conv_done, o_ovf};
        n_checks++;
        if (z_act !== '0) $display("[TB] FAIL midread_reset: got %h expected 0", z_act);
        else n_pass++;
        repeat (DEPTH + 10) cyc();
        n_checks++;
        if (done_cnt !== d0) $display("[TB] FAIL midread_no_done: got %0d pulses expected 0", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_ovf();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        i_data_din_vld = 1'b1;
        #1;
        repeat (DEPTH) cyc();
        n_checks++;
        if ({o_din_ready, o_ovf} !== 2'b00) $display("[TB] FAIL ovf_before: got %b expected 00", {o_din_ready, o_ovf});
        else n_pass++;
        cyc();
        i_data_din_vld = 1'b0;
        #1;
        n_checks++;
        if (o_ovf !== OVF_ON) $display("[TB] FAIL ovf_set: got %b expected %b", o_ovf, OVF_ON);
        else n_pass++;
        repeat (10) cyc();
        n_checks++;
        if (o_ovf !== OVF_ON) $display("[TB] FAIL ovf_sticky: got %b expected %b", o_ovf, OVF_ON);
        else n_pass++;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (o_ovf !== 1'b0) $display("[TB] FAIL ovf_clear: got %b expected 0", o_ovf);
        else n_pass++;
    endtask

    // Reference model counts words in the write bank and reads issued from the
    // ready bank; outputs are derived from those counts each cycle.
    task automatic test_random();
        int   m_fill, m_rd_idx;
        bit   m_ready, m_reading, m_sel, m_pv, m_pl, m_ovf;
        bit   e_din_ready, e_wr_en, do_swap, do_start, issue;
        logic [VEC_W-1:0] act, exp;
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        m_fill = 0; m_rd_idx = 0;
        m_ready = 0; m_reading = 0; m_sel = 0; m_pv = 0; m_pl = 0; m_ovf = 0;
        for (int c = 0; c < 6000; c++) begin
            i_rst          = ($urandom_range(0, 2999) == 0);
            i_en           = ($urandom_range(0, 9) != 0);
            i_data_din_vld = ($urandom_range(0, 9) < 8);
            i_conv_start   = ($urandom_range(0, 19) == 0);
            #1;
            e_din_ready = i_en && (m_fill < DEPTH);
            e_wr_en     = i_data_din_vld && e_din_ready;
            exp = {e_din_ready, e_wr_en, ADDR_W'(m_fill % DEPTH), m_sel, m_ready,
                   i_en && m_reading, ADDR_W'(m_reading ? m_rd_idx : 0), m_pv, m_pl, m_ovf};
            act = {o_din_ready, o_wr_en, o_wr_addr, o_switch_pingpong, o_bank_ready,
                   o_conv_addr_vld, o_conv_addr, o_conv_dout_vld, o_conv_done, o_ovf};
            n_checks++;
            if (act !== exp) $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, act, exp);
            else n_pass++;
            if (i_rst) begin
                m_fill = 0; m_rd_idx = 0;
                m_ready = 0; m_reading = 0; m_sel = 0; m_pv = 0; m_pl = 0; m_ovf = 0;
            end else begin
                do_swap  = i_en && (m_fill == DEPTH) && !m_reading && !m_ready;
                do_start = i_en && !m_reading && m_ready && i_conv_start;
                issue    = i_en && m_reading;
                if (OVF_ON && i_data_din_vld && !e_din_ready) m_ovf = 1;
                m_pv = issue;
                m_pl = issue && (m_rd_idx == DEPTH - 1);
                if (e_wr_en) m_fill++;
                if (do_swap) begin
                    m_fill = 0; m_sel = !m_sel; m_ready = 1;
                end
                if (do_start) begin
                    m_reading = 1; m_rd_idx = 0; m_ready = 0;
                end
                if (issue) begin
                    m_rd_idx++;
                    if (m_rd_idx == DEPTH) begin
                        m_reading = 0; m_rd_idx = 0;
                    end
                end
            end
            cyc();
        end
        i_rst = 1'b0; i_en = 1'b1; i_data_din_vld = 1'b0; i_conv_start = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_data_din_vld = 1'b0; i_conv_start = 1'b0;
        test_reset();
        test_fill();
        test_read_back_to_back();
        test_enable_pause();
        test_reset_midread();
        test_ovf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
